// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: state encodings and default width.
package counter_pkg;

   localparam int CNT_WIDTH_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_COUNT = 2'b01
   } state_t;

endpackage

// File: rtl/dff_en_arst.sv
// Single-bit D flop with clock enable and asynchronous active-low reset.
module dff_en_arst (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic d,
   output logic q
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q <= 1'b0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/down_counter_4bit.sv
// Loadable down counter with one-cycle terminal-count pulse and optional auto-reload.
module down_counter_4bit
   import counter_pkg::*;
#(
   parameter int WIDTH = CNT_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] q,
   output logic             busy,
   output logic             done,
   output logic             zero
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_t           state_reg, state_next;
   logic             done_reg, done_next;
   logic [WIDTH-1:0] q_reg, q_next;
   logic [WIDTH-1:0] reload_reg;
   logic             q_en;
   logic             reload_en;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bits
         dff_en_arst u_q_bit (
            .clk   (clk),
            .reset (reset),
            .en    (q_en),
            .d     (q_next[gi]),
            .q     (q_reg[gi])
         );
         dff_en_arst u_reload_bit (
            .clk   (clk),
            .reset (reset),
            .en    (reload_en),
            .d     (load_val[gi]),
            .q     (reload_reg[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= ST_IDLE;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         done_reg  <= done_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      done_next  = 1'b0;
      q_next     = q_reg;
      q_en       = 1'b0;
      reload_en  = 1'b0;
      if (load) begin
         q_next     = load_val;
         q_en       = 1'b1;
         reload_en  = 1'b1;
         state_next = (load_val != '0) ? ST_COUNT : ST_IDLE;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               state_next = ST_IDLE;
            end
            ST_COUNT: begin
               if (en) begin
                  if (q_reg == ONE) begin
                     done_next = 1'b1;
                     q_en      = 1'b1;
                     if (auto_reload) begin
                        q_next = reload_reg;
                     end else begin
                        q_next     = '0;
                        state_next = ST_IDLE;
                     end
                  end else if (q_reg != '0) begin
                     q_next = q_reg - ONE;
                     q_en   = 1'b1;
                  end else begin
                     // A zero count cannot be running; park rather than wrap.
                     state_next = ST_IDLE;
                  end
               end
            end
            default: begin
               state_next = ST_IDLE;
               q_next     = '0;
               q_en       = 1'b1;
            end
         endcase
      end
   end

   assign q    = q_reg;
   assign busy = (state_reg == ST_COUNT);
   assign done = done_reg;
   assign zero = (q_reg == '0);

endmodule

// File: tb/tb_down_counter_4bit.sv
// Scoreboarded bench: directed scenarios plus random traffic against an event-count model.
module tb_down_counter_4bit;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       load = 1'b0;
   logic [3:0] load_val = '0;
   logic       en = 1'b0;
   logic       auto_reload = 1'b0;
   logic [3:0] q;
   logic       busy, done, zero;

   logic       load8 = 1'b0;
   logic [7:0] load_val8 = '0;
   logic [7:0] q8;
   logic       busy8, done8, zero8;

   always #5 clk = ~clk;

   down_counter_4bit #(.WIDTH(4)) dut (
      .clk(clk), .reset(reset), .load(load), .load_val(load_val), .en(en),
      .auto_reload(auto_reload), .q(q), .busy(busy), .done(done), .zero(zero)
   );

   down_counter_4bit #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .load(load8), .load_val(load_val8), .en(en),
      .auto_reload(auto_reload), .q(q8), .busy(busy8), .done(done8), .zero(zero8)
   );

   typedef struct packed {
      logic [3:0] q;
      logic       busy;
      logic       done;
      logic       zero;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail = 0;

   // Model: remaining events, the programmed interval, and whether a timeout is armed.
   int m_left = 0;
   int m_interval = 0;
   bit m_armed = 0;
   bit m_pulse = 0;

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      m_left = 0;
      m_interval = 0;
      m_armed = 0;
      m_pulse = 0;
   endtask

   task automatic step(input logic ld, input logic [3:0] lv, input logic e,
                       input logic ar, input logic rn,
                       input logic ld8 = 1'b0, input logic [7:0] lv8 = 8'd0);
      exp_t x;
      @(negedge clk);
      load = ld; load_val = lv; en = e; auto_reload = ar; reset = rn;
      load8 = ld8; load_val8 = lv8;
      if (!rn) begin
         model_reset();
      end else if (ld) begin
         m_left = lv; m_interval = lv; m_armed = (lv != 0); m_pulse = 0;
      end else if (m_armed && e) begin
         m_left = m_left - 1;
         m_pulse = (m_left == 0);
         if (m_left == 0) begin
            if (ar) m_left = m_interval;
            else    m_armed = 0;
         end
      end else begin
         m_pulse = 0;
      end
      x.q = 4'(m_left);
      x.busy = m_armed;
      x.done = m_pulse;
      x.zero = (m_left == 0);
      exp_q.push_back(x);
      @(posedge clk);
   endtask

   initial begin : monitor
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            check("q", int'(q), int'(x.q));
            check("busy/done/zero", int'({busy, done, zero}), int'({x.busy, x.done, x.zero}));
         end
      end
   end

   initial begin : stimulus
      int first;
      #1 reset = 1'b0;
      #1;
      check("reset q", int'(q), 0);
      check("reset busy", int'(busy), 0);
      check("reset done", int'(done), 0);
      check("reset zero", int'(zero), 1);
      model_reset();
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1);

      // One-shot count of 5
      step(1, 4'd5, 1, 0, 1);
      for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 1);

      // Auto-reload interval of 3
      step(1, 4'd3, 1, 1, 1);
      for (int i = 0; i < 12; i++) step(0, 0, 1, 1, 1);

      // Enable gating, then IDLE hold with en high
      step(1, 4'd2, 0, 0, 1);
      step(0, 0, 1, 0, 1);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      step(0, 0, 1, 0, 1);
      for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 1);

      // Load on the terminal edge, then load of zero
      step(1, 4'd3, 1, 0, 1);
      step(0, 0, 1, 0, 1);
      step(0, 0, 1, 0, 1);
      step(1, 4'd9, 1, 0, 1);
      step(0, 0, 1, 0, 1);
      step(1, 4'd0, 1, 0, 1);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 1);

      // Reload value of 1 keeps done high
      step(1, 4'd1, 1, 1, 1);
      for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 1);

      // Asynchronous reset between edges while q = 6
      step(1, 4'd8, 1, 0, 1);
      step(0, 0, 1, 0, 1);
      step(0, 0, 1, 0, 1);
      #3 reset = 1'b0;
      model_reset();
      #1;
      check("async q", int'(q), 0);
      check("async busy", int'(busy), 0);
      check("async done", int'(done), 0);
      check("async zero", int'(zero), 1);
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 1);

      // 8-bit instance: done after exactly 255 enabled edges
      step(0, 0, 1, 0, 1, 1'b1, 8'd255);
      first = 0;
      for (int i = 1; i <= 300 && first == 0; i++) begin
         step(0, 0, 1, 0, 1);
         #2;
         if (done8) first = i;
      end
      check("w8 done edge", first, 255);
      check("w8 q at done", int'(q8), 0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(7) == 0), 4'($urandom_range(15)),
              ($urandom_range(3) != 0), 1'($urandom_range(1)),
              ($urandom_range(49) != 0));
      end

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      #2;
      check("scoreboard drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
